// File: rtl/rotation_kick_ctrl_pkg.sv
// Shared gameplay definitions: piece colours, coordinate types, board size
// and the rotation sequencer state encoding.
package rotation_kick_ctrl_pkg;

  localparam int BOARD_W = 10;
  localparam int BOARD_H = 20;

  typedef logic [2:0] color_t;
  typedef logic [1:0] rot_t;
  typedef logic [3:0] col_t;
  typedef logic [4:0] row_t;

  localparam color_t COLOR_NONE   = 3'd0;
  localparam color_t COLOR_RED    = 3'd1;
  localparam color_t COLOR_ORANGE = 3'd2;
  localparam color_t COLOR_YELLOW = 3'd3;
  localparam color_t COLOR_GREEN  = 3'd4;
  localparam color_t COLOR_BLUE   = 3'd5;
  localparam color_t COLOR_PURPLE = 3'd6;
  localparam color_t COLOR_CYAN   = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESENT,
    ST_WAIT,
    ST_NEXT,
    ST_FINISH
  } fsm_t;

  // J, L, S, T and Z pieces share one kick table.
  function automatic logic is_jlstz(input color_t c);
    return (c == COLOR_RED) || (c == COLOR_ORANGE) || (c == COLOR_GREEN) ||
           (c == COLOR_BLUE) || (c == COLOR_PURPLE);
  endfunction

endpackage

// File: rtl/rotation_kick_ctrl_kick_offset_lut.sv
// Clockwise wall-kick offsets indexed by piece colour, original rotation
// state and kick number. Purely combinational.
module rotation_kick_ctrl_kick_offset_lut
  import rotation_kick_ctrl_pkg::*;
(
  input  logic [2:0]        color,
  input  logic [1:0]        orig_state,
  input  logic [1:0]        kick_idx,
  output logic signed [2:0] dx,
  output logic signed [2:0] dy,
  output logic              kick_allowed
);

  logic signed [2:0] jx, jy, ix, iy;

  // JLSTZ offset table, row = original state, column = kick index.
  always_comb begin
    jx = 3'sd0;
    jy = 3'sd0;
    case ({orig_state, kick_idx})
      4'h0: begin jx = -3'sd1; jy =  3'sd0; end
      4'h1: begin jx = -3'sd1; jy =  3'sd1; end
      4'h2: begin jx =  3'sd0; jy = -3'sd2; end
      4'h3: begin jx = -3'sd1; jy = -3'sd2; end
      4'h4: begin jx =  3'sd1; jy =  3'sd0; end
      4'h5: begin jx =  3'sd1; jy = -3'sd1; end
      4'h6: begin jx =  3'sd0; jy =  3'sd2; end
      4'h7: begin jx =  3'sd1; jy =  3'sd2; end
      4'h8: begin jx =  3'sd1; jy =  3'sd0; end
      4'h9: begin jx =  3'sd1; jy =  3'sd1; end
      4'hA: begin jx =  3'sd0; jy = -3'sd2; end
      4'hB: begin jx =  3'sd1; jy = -3'sd2; end
      4'hC: begin jx = -3'sd1; jy =  3'sd0; end
      4'hD: begin jx = -3'sd1; jy = -3'sd1; end
      4'hE: begin jx =  3'sd0; jy =  3'sd2; end
      4'hF: begin jx = -3'sd1; jy =  3'sd2; end
    endcase
  end

  // Cyan (I piece) offset table.
  always_comb begin
    ix = 3'sd0;
    iy = 3'sd0;
    case ({orig_state, kick_idx})
      4'h0: begin ix = -3'sd2; iy =  3'sd0; end
      4'h1: begin ix =  3'sd1; iy =  3'sd0; end
      4'h2: begin ix = -3'sd2; iy = -3'sd1; end
      4'h3: begin ix =  3'sd1; iy =  3'sd2; end
      4'h4: begin ix = -3'sd1; iy =  3'sd0; end
      4'h5: begin ix =  3'sd2; iy =  3'sd0; end
      4'h6: begin ix = -3'sd1; iy =  3'sd2; end
      4'h7: begin ix =  3'sd2; iy = -3'sd1; end
      4'h8: begin ix =  3'sd2; iy =  3'sd0; end
      4'h9: begin ix = -3'sd1; iy =  3'sd0; end
      4'hA: begin ix =  3'sd2; iy =  3'sd1; end
      4'hB: begin ix = -3'sd1; iy = -3'sd2; end
      4'hC: begin ix =  3'sd1; iy =  3'sd0; end
      4'hD: begin ix = -3'sd2; iy =  3'sd0; end
      4'hE: begin ix =  3'sd1; iy = -3'sd2; end
      4'hF: begin ix = -3'sd2; iy =  3'sd1; end
    endcase
  end

  // Yellow (O piece) and the empty colour never kick.
  assign dx           = (color == COLOR_CYAN) ? ix : jx;
  assign dy           = (color == COLOR_CYAN) ? iy : jy;
  assign kick_allowed = is_jlstz(color) || (color == COLOR_CYAN);

endmodule

// File: rtl/rotation_kick_ctrl.sv
// Steps a clockwise rotation request through the plain rotation and up to
// NUM_KICKS wall kicks, presenting each in-range candidate to the board
// collision checker until one is accepted, all are rejected, or the checker
// stays silent too long.
module rotation_kick_ctrl
  import rotation_kick_ctrl_pkg::*;
#(
  parameter int NUM_KICKS      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rotate_req,
  input  logic       cancel_in,
  input  logic [2:0] block_color,
  input  logic [1:0] block_state,
  input  logic [3:0] block_x,
  input  logic [4:0] block_y,
  output logic       cand_valid,
  output logic [2:0] cand_color,
  output logic [1:0] cand_state,
  output logic [3:0] cand_x,
  output logic [4:0] cand_y,
  input  logic       check_done,
  input  logic       check_collide,
  output logic       busy,
  output logic       done,
  output logic       success,
  output logic       timeout,
  output logic [1:0] new_state,
  output logic [3:0] new_x,
  output logic [4:0] new_y
);

  localparam int                WAIT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
  localparam logic [2:0]        KICK_LIMIT = 3'(NUM_KICKS);

  fsm_t              state_reg;
  logic [2:0]        attempt_reg;
  logic [WAIT_W-1:0] wait_cnt_reg;
  color_t            lat_color_reg;
  rot_t              lat_state_reg;
  col_t              lat_x_reg;
  row_t              lat_y_reg;
  logic              cand_valid_reg;
  color_t            cand_color_reg;
  rot_t              cand_state_reg;
  col_t              cand_x_reg;
  row_t              cand_y_reg;
  logic              busy_reg, done_reg, success_reg, timeout_reg;
  rot_t              new_state_reg;
  col_t              new_x_reg;
  row_t              new_y_reg;

  logic signed [2:0] kick_dx, kick_dy;
  logic              kick_allowed;
  logic signed [5:0] sum_x, sum_y;
  logic              sum_in_range;

  // In NEXT, attempt_reg still holds the attempt just rejected, which is
  // exactly the kick index of the following attempt.
  rotation_kick_ctrl_kick_offset_lut u_lut (
    .color        (lat_color_reg),
    .orig_state   (lat_state_reg),
    .kick_idx     (attempt_reg[1:0]),
    .dx           (kick_dx),
    .dy           (kick_dy),
    .kick_allowed (kick_allowed)
  );

  // 6-bit signed sums: negative or x above 15 means off the coordinate range.
  // A y sum above 31 wraps negative, so the sign bit alone covers it.
  assign sum_x = $signed({2'b00, lat_x_reg}) + $signed({{3{kick_dx[2]}}, kick_dx});
  assign sum_y = $signed({1'b0, lat_y_reg}) + $signed({{3{kick_dy[2]}}, kick_dy});
  assign sum_in_range = !sum_x[5] && !sum_x[4] && !sum_y[5];

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg      <= ST_IDLE;
      attempt_reg    <= '0;
      wait_cnt_reg   <= '0;
      lat_color_reg  <= '0;
      lat_state_reg  <= '0;
      lat_x_reg      <= '0;
      lat_y_reg      <= '0;
      cand_valid_reg <= 1'b0;
      cand_color_reg <= '0;
      cand_state_reg <= '0;
      cand_x_reg     <= '0;
      cand_y_reg     <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      success_reg    <= 1'b0;
      timeout_reg    <= 1'b0;
      new_state_reg  <= '0;
      new_x_reg      <= '0;
      new_y_reg      <= '0;
    end else if (cancel_in) begin
      // Abandon the sequence silently; result registers keep their values.
      state_reg      <= ST_IDLE;
      cand_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (rotate_req) begin
            lat_color_reg <= block_color;
            lat_state_reg <= block_state;
            lat_x_reg     <= block_x;
            lat_y_reg     <= block_y;
            attempt_reg   <= '0;
            success_reg   <= 1'b0;
            timeout_reg   <= 1'b0;
            if (block_color == COLOR_NONE) begin
              new_state_reg <= block_state;
              new_x_reg     <= block_x;
              new_y_reg     <= block_y;
              done_reg      <= 1'b1;
              state_reg     <= ST_FINISH;
            end else begin
              busy_reg       <= 1'b1;
              cand_valid_reg <= 1'b1;
              cand_color_reg <= block_color;
              cand_state_reg <= block_state + 2'd1;
              cand_x_reg     <= block_x;
              cand_y_reg     <= block_y;
              state_reg      <= ST_PRESENT;
            end
          end
        end
        ST_PRESENT: begin
          wait_cnt_reg <= '0;
          state_reg    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (check_done && !check_collide) begin
            success_reg    <= 1'b1;
            new_state_reg  <= cand_state_reg;
            new_x_reg      <= cand_x_reg;
            new_y_reg      <= cand_y_reg;
            cand_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b1;
            state_reg      <= ST_FINISH;
          end else if (check_done) begin
            cand_valid_reg <= 1'b0;
            state_reg      <= ST_NEXT;
          end else if (wait_cnt_reg == WAIT_LAST) begin
            timeout_reg    <= 1'b1;
            new_state_reg  <= lat_state_reg;
            new_x_reg      <= lat_x_reg;
            new_y_reg      <= lat_y_reg;
            cand_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b1;
            state_reg      <= ST_FINISH;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + WAIT_ONE;
          end
        end
        ST_NEXT: begin
          // Out-of-range kicks stay here one cycle each, as if rejected.
          attempt_reg <= attempt_reg + 3'd1;
          if ((attempt_reg >= KICK_LIMIT) || !kick_allowed) begin
            new_state_reg <= lat_state_reg;
            new_x_reg     <= lat_x_reg;
            new_y_reg     <= lat_y_reg;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b1;
            state_reg     <= ST_FINISH;
          end else if (sum_in_range) begin
            cand_x_reg     <= sum_x[3:0];
            cand_y_reg     <= sum_y[4:0];
            cand_valid_reg <= 1'b1;
            state_reg      <= ST_PRESENT;
          end
        end
        ST_FINISH: state_reg <= ST_IDLE;
        default:   state_reg <= ST_IDLE;
      endcase
    end
  end

  assign cand_valid = cand_valid_reg;
  assign cand_color = cand_color_reg;
  assign cand_state = cand_state_reg;
  assign cand_x     = cand_x_reg;
  assign cand_y     = cand_y_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign success    = success_reg;
  assign timeout    = timeout_reg;
  assign new_state  = new_state_reg;
  assign new_x      = new_x_reg;
  assign new_y      = new_y_reg;

endmodule

// File: tb/tb_rotation_kick_ctrl.sv
// Scoreboard bench for rotation_kick_ctrl: a list-based kick model predicts
// the candidates and the final result, a responder plays the collision
// checker, and a monitor compares every candidate and done pulse.
module tb_rotation_kick_ctrl;

  localparam int NUM_KICKS      = 4;
  localparam int TIMEOUT_CYCLES = 16;

  logic       clk_in = 1'b0;
  logic       rst_in, rotate_req, cancel_in;
  logic [2:0] block_color;
  logic [1:0] block_state;
  logic [3:0] block_x;
  logic [4:0] block_y;
  logic       cand_valid;
  logic [2:0] cand_color;
  logic [1:0] cand_state;
  logic [3:0] cand_x;
  logic [4:0] cand_y;
  logic       check_done, check_collide;
  logic       busy, done, success, timeout;
  logic [1:0] new_state;
  logic [3:0] new_x;
  logic [4:0] new_y;

  rotation_kick_ctrl #(.NUM_KICKS(NUM_KICKS), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rotate_req(rotate_req), .cancel_in(cancel_in),
    .block_color(block_color), .block_state(block_state), .block_x(block_x), .block_y(block_y),
    .cand_valid(cand_valid), .cand_color(cand_color), .cand_state(cand_state),
    .cand_x(cand_x), .cand_y(cand_y), .check_done(check_done), .check_collide(check_collide),
    .busy(busy), .done(done), .success(success), .timeout(timeout),
    .new_state(new_state), .new_x(new_x), .new_y(new_y)
  );

  always #5 clk_in = ~clk_in;

  typedef struct { int color; int st; int x; int y; } cand_t;
  typedef struct { int succ; int tmo; int st; int x; int y; } res_t;

  cand_t exp_cand[$];
  res_t  exp_res[$];
  cand_t mon_c;
  res_t  mon_r;

  int n_chk = 0;
  int n_err = 0;
  bit silent = 1'b0;
  int rejects_left = 0;
  int resp_lat;
  bit resp_seen = 1'b0;
  bit resp_rej;
  bit mon_prev_cv = 1'b0;
  int last_st = 0, last_x = 0, last_y = 0;

  // Clockwise kick offsets, [original state][kick index].
  int j_dx[4][4] = '{'{-1, -1, 0, -1}, '{1, 1, 0, 1}, '{1, 1, 0, 1}, '{-1, -1, 0, -1}};
  int j_dy[4][4] = '{'{0, 1, -2, -2}, '{0, -1, 2, 2}, '{0, 1, -2, -2}, '{0, -1, 2, 2}};
  int i_dx[4][4] = '{'{-2, 1, -2, 1}, '{-1, 2, -1, 2}, '{2, -1, 2, -1}, '{1, -2, 1, -2}};
  int i_dy[4][4] = '{'{0, 0, -1, 2}, '{0, 0, 2, -1}, '{0, 0, 1, -2}, '{0, 0, -2, 1}};

  task automatic chk(input string name, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic int all_outs();
    return int'({cand_valid, cand_color, cand_state, cand_x, cand_y, busy, done,
                 success, timeout, new_state, new_x, new_y});
  endfunction

  // Reference model: list every in-range candidate, then let the checker
  // reject the first rej of them.
  task automatic plan(input int color, input int st, input int x, input int y,
                      input int rej, input bit silent_m, input bit expect_done);
    int cx[$];
    int cy[$];
    int lim, nx, ny, npush;
    if (color != 0) begin
      cx.push_back(x);
      cy.push_back(y);
      lim = (color == 3) ? 0 : NUM_KICKS;
      for (int k = 0; k < lim; k++) begin
        nx = x + ((color == 7) ? i_dx[st][k] : j_dx[st][k]);
        ny = y + ((color == 7) ? i_dy[st][k] : j_dy[st][k]);
        if (nx >= 0 && nx <= 15 && ny >= 0 && ny <= 31) begin
          cx.push_back(nx);
          cy.push_back(ny);
        end
      end
    end
    if (color == 0) begin
      if (expect_done) exp_res.push_back('{succ: 0, tmo: 0, st: st, x: x, y: y});
    end else if (silent_m) begin
      exp_cand.push_back('{color: color, st: (st + 1) % 4, x: cx[0], y: cy[0]});
      if (expect_done) exp_res.push_back('{succ: 0, tmo: 1, st: st, x: x, y: y});
    end else begin
      npush = (rej < cx.size()) ? rej + 1 : cx.size();
      for (int i = 0; i < npush; i++)
        exp_cand.push_back('{color: color, st: (st + 1) % 4, x: cx[i], y: cy[i]});
      if (!expect_done) begin
      end else if (rej < cx.size())
        exp_res.push_back('{succ: 1, tmo: 0, st: (st + 1) % 4, x: cx[rej], y: cy[rej]});
      else
        exp_res.push_back('{succ: 0, tmo: 0, st: st, x: x, y: y});
    end
  endtask

  // Monitor: compare every presented candidate and every done pulse.
  initial begin : monitor
    forever begin
      @(negedge clk_in);
      if (cand_valid === 1'b1 && !mon_prev_cv) begin
        if (exp_cand.size() == 0) chk("unexpected_cand", 1, 0);
        else begin
          mon_c = exp_cand.pop_front();
          chk("cand_color", int'(cand_color), mon_c.color);
          chk("cand_state", int'(cand_state), mon_c.st);
          chk("cand_x", int'(cand_x), mon_c.x);
          chk("cand_y", int'(cand_y), mon_c.y);
        end
      end
      mon_prev_cv = (cand_valid === 1'b1);
      if (done === 1'b1) begin
        if (exp_res.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          mon_r = exp_res.pop_front();
          chk("done_success", int'(success), mon_r.succ);
          chk("done_timeout", int'(timeout), mon_r.tmo);
          chk("done_busy_low", int'(busy), 0);
          chk("new_state", int'(new_state), mon_r.st);
          chk("new_x", int'(new_x), mon_r.x);
          chk("new_y", int'(new_y), mon_r.y);
          last_st = mon_r.st;
          last_x  = mon_r.x;
          last_y  = mon_r.y;
        end
      end
    end
  end

  // Collision checker stand-in: answers each candidate after 1..4 cycles.
  initial begin : responder
    check_done    = 1'b0;
    check_collide = 1'b0;
    forever begin
      @(negedge clk_in);
      if (cand_valid !== 1'b1) resp_seen = 1'b0;
      else if (!resp_seen) begin
        resp_seen = 1'b1;
        if (!silent) begin
          resp_lat = $urandom_range(0, 3);
          repeat (resp_lat + 1) @(negedge clk_in);
          resp_rej = (rejects_left > 0);
          if (resp_rej) rejects_left--;
          check_done    = 1'b1;
          check_collide = resp_rej;
          @(negedge clk_in);
          check_done    = 1'b0;
          check_collide = 1'b0;
          if (!resp_rej) chk("accept_to_done", int'(done), 1);
          resp_seen = 1'b0;
        end
      end
    end
  end

  task automatic issue(input int color, input int st, input int x, input int y);
    block_color = 3'(color);
    block_state = 2'(st);
    block_x     = 4'(x);
    block_y     = 5'(y);
    rotate_req  = 1'b1;
    @(negedge clk_in);
    rotate_req  = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 400) begin
      @(negedge clk_in);
      cyc++;
    end
    if (done !== 1'b1) chk("done_within_bound", 0, 1);
  endtask

  task automatic run_txn(input string tag, input int color, input int st,
                         input int x, input int y, input int rej);
    int cyc;
    silent = 1'b0;
    rejects_left = rej;
    plan(color, st, x, y, rej, 1'b0, 1'b1);
    issue(color, st, x, y);
    if (color != 0) begin
      chk("req_to_cand_valid", int'(cand_valid), 1);
      chk("req_to_busy", int'(busy), 1);
    end else begin
      chk("nocolor_done", int'(done), 1);
    end
    wait_done(cyc);
    repeat (2) @(negedge clk_in);
    chk("scoreboard_drained", exp_cand.size() + exp_res.size(), 0);
    $display("txn %s color=%0d st=%0d pos=(%0d,%0d) rej=%0d -> success=%0d new=(%0d,%0d,s%0d) cycles=%0d",
             tag, color, st, x, y, rej, success, new_x, new_y, new_state, cyc);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int cyc;
    rst_in = 1'b1; rotate_req = 1'b0; cancel_in = 1'b0;
    block_color = '0; block_state = '0; block_x = '0; block_y = '0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    chk("reset_outputs", all_outs(), 0);
    $display("txn reset -> outputs=%0h", all_outs());

    run_txn("red_kick0", 1, 0, 5, 10, 1);
    run_txn("cyan_three_rejects", 7, 2, 1, 8, 3);
    run_txn("red_left_edge_skip", 1, 0, 0, 10, 1);
    run_txn("yellow_no_kicks", 3, 3, 4, 4, 1);
    run_txn("red_all_rejected", 1, 0, 0, 10, 9);

    // Silent checker: one candidate, then timeout after TIMEOUT_CYCLES.
    silent = 1'b1;
    plan(4, 1, 6, 6, 0, 1'b1, 1'b1);
    issue(4, 1, 6, 6);
    wait_done(cyc);
    chk("timeout_latency", cyc, TIMEOUT_CYCLES + 1);
    repeat (2) @(negedge clk_in);
    $display("txn timeout -> timeout=%0d success=%0d cycles=%0d", timeout, success, cyc);

    // Cancel during WAIT, with an ignored request while busy.
    plan(6, 0, 7, 7, 0, 1'b1, 1'b0);
    issue(6, 0, 7, 7);
    repeat (3) @(negedge clk_in);
    issue(1, 2, 2, 3);
    chk("busy_req_ignored_x", int'(cand_x), 7);
    chk("busy_req_ignored_color", int'(cand_color), 6);
    chk("still_busy", int'(busy), 1);
    cancel_in = 1'b1;
    @(negedge clk_in);
    cancel_in = 1'b0;
    chk("cancel_cand_valid", int'(cand_valid), 0);
    chk("cancel_busy", int'(busy), 0);
    chk("cancel_held_new", int'({new_state, new_x, new_y}), (last_st << 9) | (last_x << 5) | last_y);
    chk("req_cleared_timeout", int'(timeout), 0);
    repeat (20) @(negedge clk_in);
    chk("cancel_drained", exp_cand.size() + exp_res.size(), 0);
    $display("txn cancel -> busy=%0d done=%0d", busy, done);

    // Reset in the middle of WAIT.
    plan(2, 1, 8, 8, 0, 1'b1, 1'b0);
    issue(2, 1, 8, 8);
    repeat (4) @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    chk("reset_mid_wait_outputs", all_outs(), 0);
    last_st = 0; last_x = 0; last_y = 0;
    repeat (5) @(negedge clk_in);
    chk("reset_drained", exp_cand.size() + exp_res.size(), 0);
    $display("txn reset_mid_wait -> outputs=%0h", all_outs());

    for (int t = 0; t < 24; t++)
      run_txn("random", int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 5)));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/rotation_kick_ctrl.md
Name: rotation_kick_ctrl

Overview:
- Consumer side of the SRS kick-offset table: sequences a clockwise rotation request through the plain rotation, then kicks 0..3, until the board collision checker accepts one candidate or all are rejected.
- Sits between gameplay input/FSM (issues rotate requests, applies result) and the board collision checker (variable-latency handshake).

Parameters:
- NUM_KICKS, 4, kick attempts after the plain rotation (1..4)
- TIMEOUT_CYCLES, 16, max cycles to wait for check_done per candidate before abort

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- rotate_req  in  1  one-cycle request, sampled only in IDLE
- cancel_in  in  1  abort current sequence (piece locked / new game)
- block_color  in  3  0=none,1 red,2 orange,3 yellow,4 green,5 blue,6 purple,7 cyan
- block_state  in  2  current rotation state
- block_x  in  4  current origin column
- block_y  in  5  current origin row
- cand_valid  out  1  candidate presented to checker
- cand_color  out  3  candidate piece
- cand_state  out  2  candidate rotation state (block_state+1 mod 4)
- cand_x  out  4  candidate column
- cand_y  out  5  candidate row
- check_done  in  1  checker result strobe (only meaningful while cand_valid)
- check_collide  in  1  1 = candidate collides, qualified by check_done
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- success  out  1  rotation accepted (valid with done, held until next request)
- timeout  out  1  abort due to checker silence (valid with done, held)
- new_state  out  2  accepted state (held)
- new_x  out  4  accepted column (held)
- new_y  out  5  accepted row (held)

Behaviour:
- Reset: all outputs 0; FSM to IDLE; attempt counter 0. Reset mid-sequence discards it, no done.
- States: IDLE, PRESENT, WAIT, NEXT, FINISH.
- IDLE: rotate_req=1 latches color/state/x/y, attempt=0, clears success/timeout, busy=1 next cycle. color=0 -> FINISH with success=0. rotate_req while busy ignored.
- Candidate generation: attempt 0 = latched (x,y); attempt k (1..NUM_KICKS) = kick offset index k-1 by latched color and ORIGINAL state. Yellow: attempt 0 only. cand_state always latched state+1 mod 4.
- Offsets (x,y) by orig state, JLSTZ: s0 (-1,0)(-1,+1)(0,-2)(-1,-2); s1 (+1,0)(+1,-1)(0,+2)(+1,+2); s2 (+1,0)(+1,+1)(0,-2)(+1,-2); s3 (-1,0)(-1,-1)(0,+2)(-1,+2). Cyan: s0 (-2,0)(+1,0)(-2,-1)(+1,+2); s1 (-1,0)(+2,0)(-1,+2)(+2,-1); s2 (+2,0)(-1,0)(+2,+1)(-1,-2); s3 (+1,0)(-2,0)(+1,-2)(-2,+1).
- Arithmetic: sums in signed 6-bit; result <0 or >15 (x) / >31 (y) = out-of-range; candidate skipped without asserting cand_valid (treated as collide, via NEXT).
- PRESENT: cand_valid=1 and candidate fields stable; go WAIT same cycle-boundary (cand_valid stays 1 through WAIT).
- WAIT: check_done&!collide -> FINISH success=1, new_* = candidate. check_done&collide -> NEXT. No check_done for TIMEOUT_CYCLES cycles -> FINISH success=0, timeout=1.
- NEXT: cand_valid=0 exactly one cycle; attempt++; if attempt > limit (NUM_KICKS, or 0 for yellow) -> FINISH success=0; else PRESENT.
- FINISH: done=1 one cycle, busy=0 same cycle -> IDLE. On failure new_* = latched original position/state.
- Latency: req at N -> cand_valid at N+1; accept at M -> done at M+1. Each rejected candidate costs check latency + 1 idle cycle.
- cancel_in (priority below reset, above all else): any non-IDLE state -> IDLE next cycle, cand_valid/busy drop, no done, held outputs unchanged.
- check_done outside WAIT ignored.

Decomposition:
- Shared gameplay package: piece color constants, state/coord typedefs (2/4/5-bit), BOARD_W=10, BOARD_H=20.
- One combinational sub-module kick_offset_lut: (color, orig_state, kick_idx) -> signed 3-bit dx, dy, plus kick_allowed flag. FSM and range check remain here.

Test Plan:
- Red s0 (5,10); attempt0 rejected, kick0 accepted -> cand (5,10,s1) then (4,10,s1); done success=1 new=(4,10,1).
- Cyan s2 (1,8), checker rejects 3 -> candidates (1,8),(3,8),(0,8),(3,9); accept 4th -> new=(3,9,3).
- Red s0 x=0 y=10, reject attempt0 -> kick0 x=-1 skipped (no cand_valid), next cand (15?) no: kick1 also skipped, kick2 (0,8) presented.
- Yellow s3 (4,4) reject attempt0 -> done success=0, new=(4,4,3), only one cand_valid.
- Checker silent 16 cycles -> done, success=0, timeout=1; cancel_in during WAIT -> IDLE, no done.
- rst_in mid-WAIT -> all outputs 0 next cycle; rotate_req while busy ignored.
